// File: rtl/ibex_pkg.sv
// Shared interrupt definitions: exception cause codes and arbiter FSM states.
package ibex_pkg;

    localparam int unsigned EXC_CAUSE_W = 6;

    localparam logic [EXC_CAUSE_W-1:0] EXC_CAUSE_IRQ_NM         = 6'd63;
    localparam logic [EXC_CAUSE_W-1:0] EXC_CAUSE_IRQ_EXTERNAL_M = 6'd43;
    localparam logic [EXC_CAUSE_W-1:0] EXC_CAUSE_IRQ_SOFTWARE_M = 6'd35;
    localparam logic [EXC_CAUSE_W-1:0] EXC_CAUSE_IRQ_TIMER_M    = 6'd39;
    localparam logic [EXC_CAUSE_W-1:0] EXC_CAUSE_IRQ_FAST_BASE  = 6'd48;

    // Arbiter lifecycle of one presented interrupt
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        HOLDOFF = 2'd2
    } irq_arb_state_e;

    // Source index layout (low to high priority):
    //   0 timer, 1 software, 2 external, 3+i fast[i], num_fast+3 NMI.
    // The low num_fast+3 indices line up with the mie/mip bit order.
    function automatic logic [EXC_CAUSE_W-1:0] irq_idx_to_cause(
        input int unsigned idx,
        input int unsigned num_fast
    );
        logic [EXC_CAUSE_W-1:0] cause;
        if (idx == num_fast + 3) begin
            cause = EXC_CAUSE_IRQ_NM;
        end else if (idx >= 3) begin
            cause = EXC_CAUSE_IRQ_FAST_BASE + EXC_CAUSE_W'(idx - 3);
        end else if (idx == 2) begin
            cause = EXC_CAUSE_IRQ_EXTERNAL_M;
        end else if (idx == 1) begin
            cause = EXC_CAUSE_IRQ_SOFTWARE_M;
        end else begin
            cause = EXC_CAUSE_IRQ_TIMER_M;
        end
        return cause;
    endfunction

endpackage

// File: rtl/ibex_irq_prio_enc.sv
// Combinational fixed-priority encoder: the highest set request index wins.
module ibex_irq_prio_enc #(
    parameter int unsigned WIDTH = 19,
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Ascending scan so the last (highest) set bit overrides lower ones
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (req_i[i]) begin
                idx_o   = IDX_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ibex_irq_arbiter.sv
// Interrupt scheduler: latches/masks machine interrupt sources, picks a
// fixed-priority winner and holds it stable for the controller until taken.
module ibex_irq_arbiter
    import ibex_pkg::*;
#(
    parameter int unsigned          NUM_FAST       = 15,
    parameter logic [NUM_FAST-1:0]  FAST_EDGE_MASK = '0,
    parameter int unsigned          HOLDOFF_CYCLES = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    irq_nm_i,
    input  logic [NUM_FAST-1:0]     irq_fast_i,
    input  logic                    irq_external_i,
    input  logic                    irq_software_i,
    input  logic                    irq_timer_i,
    input  logic [NUM_FAST+2:0]     csr_mie_i,
    input  logic                    csr_mstatus_mie_i,
    input  logic                    nmi_mode_i,
    input  logic                    debug_mode_i,
    input  logic                    irq_ack_i,
    output logic                    irq_req_o,
    output logic                    irq_nmi_o,
    output logic [EXC_CAUSE_W-1:0]  irq_cause_o,
    output logic [NUM_FAST+2:0]     csr_mip_o
);

    localparam int unsigned NUM_MIE = NUM_FAST + 3;
    localparam int unsigned NUM_SRC = NUM_FAST + 4;
    localparam int unsigned NMI_IDX = NUM_SRC - 1;
    localparam int unsigned IDX_W   = $clog2(NUM_SRC);
    localparam int unsigned CNT_W   = 3;

    // Input history and edge latches
    logic                   nmi_prev_q;
    logic                   nmi_lat_q;
    logic                   nmi_lat_d;
    logic [NUM_FAST-1:0]    fast_prev_q;
    logic [NUM_FAST-1:0]    fast_lat_q;
    logic [NUM_FAST-1:0]    fast_lat_d;

    // Pending / eligibility view
    logic                   nmi_rise_c;
    logic                   nmi_pend_c;
    logic [NUM_FAST-1:0]    fast_rise_c;
    logic [NUM_FAST-1:0]    fast_pend_c;
    logic [NUM_MIE-1:0]     mip_c;
    logic [NUM_MIE-1:0]     mip_q;
    logic                   maskable_en_c;
    logic [NUM_SRC-1:0]     elig_c;

    // Arbitration
    logic [IDX_W-1:0]       win_idx_c;
    logic                   win_valid_c;
    logic [IDX_W-1:0]       win_idx_q;
    logic                   win_elig_c;
    logic                   retire_c;
    logic                   nmi_clr_c;
    logic [NUM_FAST-1:0]    fast_clr_c;

    // FSM and registered outputs
    irq_arb_state_e         state_q;
    logic [CNT_W-1:0]       hold_cnt_q;
    logic                   req_q;
    logic                   nmi_q;
    logic [EXC_CAUSE_W-1:0] cause_q;

    // Raw pending: edge sources include this cycle's rising edge so they are
    // visible with the same latency as level sources
    always_comb begin
        nmi_rise_c  = irq_nm_i & ~nmi_prev_q;
        nmi_pend_c  = nmi_lat_q | nmi_rise_c;
        fast_rise_c = irq_fast_i & ~fast_prev_q;
        fast_pend_c = (FAST_EDGE_MASK & (fast_lat_q | fast_rise_c))
                    | (~FAST_EDGE_MASK & irq_fast_i);
        mip_c       = {fast_pend_c, irq_external_i, irq_software_i, irq_timer_i};
    end

    // Eligibility after masking; index order doubles as priority order
    always_comb begin
        maskable_en_c = csr_mstatus_mie_i & ~debug_mode_i;
        elig_c        = {nmi_pend_c & ~nmi_mode_i & ~debug_mode_i,
                         mip_c & csr_mie_i & {NUM_MIE{maskable_en_c}}};
    end

    ibex_irq_prio_enc #(
        .WIDTH   (NUM_SRC)
    ) u_prio_enc (
        .req_i   (elig_c),
        .idx_o   (win_idx_c),
        .valid_o (win_valid_c)
    );

    // Retirement of the presented winner; acks outside PRESENT are ignored
    always_comb begin
        retire_c   = (state_q == PRESENT) & irq_ack_i;
        win_elig_c = elig_c[win_idx_q];
        nmi_clr_c  = retire_c & (win_idx_q == IDX_W'(NMI_IDX));
        fast_clr_c = '0;
        for (int unsigned i = 0; i < NUM_FAST; i++) begin
            fast_clr_c[i] = retire_c & (win_idx_q == IDX_W'(i + 3));
        end
    end

    // Latch next state: a new edge in the same cycle as its ack keeps it set
    always_comb begin
        nmi_lat_d  = (nmi_lat_q & ~nmi_clr_c) | nmi_rise_c;
        fast_lat_d = FAST_EDGE_MASK & ((fast_lat_q & ~fast_clr_c) | fast_rise_c);
    end

    // Source history, edge latches and registered pending view
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            nmi_prev_q  <= 1'b0;
            nmi_lat_q   <= 1'b0;
            fast_prev_q <= '0;
            fast_lat_q  <= '0;
            mip_q       <= '0;
        end else begin
            nmi_prev_q  <= irq_nm_i;
            nmi_lat_q   <= nmi_lat_d;
            fast_prev_q <= irq_fast_i;
            fast_lat_q  <= fast_lat_d;
            mip_q       <= mip_c;
        end
    end

    // Presentation FSM with registered request/cause; outputs frozen in PRESENT
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            win_idx_q  <= '0;
            req_q      <= 1'b0;
            nmi_q      <= 1'b0;
            cause_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_valid_c) begin
                        state_q   <= PRESENT;
                        win_idx_q <= win_idx_c;
                        req_q     <= 1'b1;
                        nmi_q     <= (win_idx_c == IDX_W'(NMI_IDX));
                        cause_q   <= irq_idx_to_cause(32'(win_idx_c), NUM_FAST);
                    end
                end
                PRESENT: begin
                    if (irq_ack_i) begin
                        state_q    <= HOLDOFF;
                        hold_cnt_q <= CNT_W'(HOLDOFF_CYCLES);
                        req_q      <= 1'b0;
                        nmi_q      <= 1'b0;
                        cause_q    <= '0;
                    end else if (!win_elig_c) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                        nmi_q   <= 1'b0;
                        cause_q <= '0;
                    end
                end
                HOLDOFF: begin
                    hold_cnt_q <= hold_cnt_q - CNT_W'(1);
                    if (hold_cnt_q <= CNT_W'(1)) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    nmi_q   <= 1'b0;
                    cause_q <= '0;
                end
            endcase
        end
    end

    assign irq_req_o   = req_q;
    assign irq_nmi_o   = nmi_q;
    assign irq_cause_o = cause_q;
    assign csr_mip_o   = mip_q;

endmodule

// File: tb/tb_ibex_irq_arbiter.sv
// Directed bench for ibex_irq_arbiter with a priority-list reference model.
module tb_ibex_irq_arbiter;

    localparam int unsigned  NF   = 15;
    localparam logic [NF-1:0] EDGE = 15'h0004;
    localparam int           HOLD = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           nm;
    logic [NF-1:0]  fast;
    logic           ext, sw, tmr;
    logic [NF+2:0]  mie;
    logic           mst, nmi_mode, dbg, ack;
    logic           irq_req_o, irq_nmi_o;
    logic [5:0]     irq_cause_o;
    logic [NF+2:0]  csr_mip_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ibex_irq_arbiter #(
        .NUM_FAST          (NF),
        .FAST_EDGE_MASK    (EDGE),
        .HOLDOFF_CYCLES    (HOLD)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .irq_nm_i          (nm),
        .irq_fast_i        (fast),
        .irq_external_i    (ext),
        .irq_software_i    (sw),
        .irq_timer_i       (tmr),
        .csr_mie_i         (mie),
        .csr_mstatus_mie_i (mst),
        .nmi_mode_i        (nmi_mode),
        .debug_mode_i      (dbg),
        .irq_ack_i         (ack),
        .irq_req_o         (irq_req_o),
        .irq_nmi_o         (irq_nmi_o),
        .irq_cause_o       (irq_cause_o),
        .csr_mip_o         (csr_mip_o)
    );

    // Reference model. Sources kept in a priority list, slot 0 = highest:
    // 0 NMI, 1..15 fast[14]..fast[0], 16 external, 17 software, 18 timer.
    int          m_phase = 0;   // 0 waiting, 1 presenting, 2 holding off
    int          m_hold  = 0;
    int          m_win   = 0;   // slot being presented
    bit          m_nmi_lat = 0, m_nm_prev = 0;
    bit [NF-1:0] m_flat = '0, m_fprev = '0;
    bit          m_req = 0, m_nmi = 0;
    int          m_cause = 0;
    bit [NF+2:0] m_mip = '0;

    function automatic int slot_cause(input int s);
        if (s == 0)  return 63;
        if (s <= 15) return 48 + (15 - s);
        if (s == 16) return 43;
        if (s == 17) return 35;
        return 39;
    endfunction

    task automatic model_step();
        bit          pend [19];
        bit          elig [19];
        bit          rise_nm;
        bit [NF-1:0] rise_f;
        int          first;
        int          retired;
        if (rst) begin
            m_phase = 0; m_hold = 0; m_win = 0;
            m_nmi_lat = 0; m_nm_prev = 0; m_flat = '0; m_fprev = '0;
            m_req = 0; m_nmi = 0; m_cause = 0; m_mip = '0;
            return;
        end
        rise_nm = nm && !m_nm_prev;
        rise_f  = fast & ~m_fprev;
        pend[0] = m_nmi_lat || rise_nm;
        elig[0] = pend[0] && !nmi_mode && !dbg;
        for (int s = 1; s <= 15; s++) begin
            int i;
            i = 15 - s;
            pend[s] = EDGE[i] ? (m_flat[i] || rise_f[i]) : fast[i];
            elig[s] = pend[s] && mie[3+i] && mst && !dbg;
        end
        pend[16] = ext; elig[16] = ext && mie[2] && mst && !dbg;
        pend[17] = sw;  elig[17] = sw  && mie[1] && mst && !dbg;
        pend[18] = tmr; elig[18] = tmr && mie[0] && mst && !dbg;
        first = -1;
        for (int s = 0; s < 19; s++) if (elig[s] && first < 0) first = s;
        for (int i = 0; i < int'(NF); i++) m_mip[3+i] = pend[15-i];
        m_mip[2] = ext; m_mip[1] = sw; m_mip[0] = tmr;

        retired = -1;
        if (m_phase == 0) begin
            if (first >= 0) begin m_phase = 1; m_win = first; end
        end else if (m_phase == 1) begin
            if (ack) begin retired = m_win; m_phase = 2; m_hold = HOLD; end
            else if (!elig[m_win]) m_phase = 0;
        end else begin
            m_hold--;
            if (m_hold == 0) m_phase = 0;
        end

        m_nmi_lat = (m_nmi_lat && retired != 0) || rise_nm;
        for (int i = 0; i < int'(NF); i++)
            if (EDGE[i]) m_flat[i] = (m_flat[i] && retired != 15 - i) || rise_f[i];
        m_nm_prev = nm;
        m_fprev   = fast;

        m_req   = (m_phase == 1);
        m_nmi   = m_req && (m_win == 0);
        m_cause = m_req ? slot_cause(m_win) : 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: model follows the same sampled inputs, outputs checked #1 later
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("model_req", 32'(irq_req_o), 32'(m_req));
        chk("model_mip", 32'(csr_mip_o), 32'(m_mip));
        if (m_req) begin
            chk("model_cause", 32'(irq_cause_o), m_cause);
            chk("model_nmi", 32'(irq_nmi_o), 32'(m_nmi));
        end
    endtask

    task automatic ack_cyc();
        ack = 1'b1;
        cyc();
        ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; nm = 1'b0; fast = '0; ext = 1'b0; sw = 1'b0; tmr = 1'b0;
        mie = '1; mst = 1'b1; nmi_mode = 1'b0; dbg = 1'b0; ack = 1'b0;
        cyc(); cyc();
        chk("reset_req", 32'(irq_req_o), 0);
        chk("reset_cause", 32'(irq_cause_o), 0);
        chk("reset_mip", 32'(csr_mip_o), 0);
        rst = 1'b0;
        cyc();

        // Timer: present, ack, holdoff, re-present
        tmr = 1'b1; cyc();
        chk("t1_req", 32'(irq_req_o), 1);
        chk("t1_cause", 32'(irq_cause_o), 39);
        cyc();
        ack_cyc();
        chk("t1_ack_drop", 32'(irq_req_o), 0);
        cyc();
        chk("t1_holdoff", 32'(irq_req_o), 0);
        cyc();
        chk("t1_represent", 32'(irq_req_o), 1);
        chk("t1_recause", 32'(irq_cause_o), 39);
        tmr = 1'b0; cyc();
        chk("t1_withdraw", 32'(irq_req_o), 0);
        cyc();

        // Fast[3] over external; fast[10] arriving mid-present does not pre-empt
        fast[3] = 1'b1; ext = 1'b1; cyc();
        chk("t2_cause51", 32'(irq_cause_o), 51);
        fast[10] = 1'b1; cyc();
        chk("t2_frozen", 32'(irq_cause_o), 51);
        ack_cyc(); cyc(); cyc();
        chk("t2_req", 32'(irq_req_o), 1);
        chk("t2_cause58", 32'(irq_cause_o), 58);
        fast = '0; ext = 1'b0; cyc(); cyc();

        // Edge fast[2] pulse while globally masked; stray ack must not clear it
        mst = 1'b0;
        fast[2] = 1'b1; cyc();
        fast[2] = 1'b0; cyc();
        chk("t3_mip_held", 32'(csr_mip_o[5]), 1);
        chk("t3_masked", 32'(irq_req_o), 0);
        ack_cyc(); cyc();
        chk("t3_stray_ack", 32'(csr_mip_o[5]), 1);
        mst = 1'b1; cyc();
        chk("t3_cause50", 32'(irq_cause_o), 50);
        ack_cyc(); cyc(); cyc(); cyc();
        chk("t3_no_repres", 32'(irq_req_o), 0);
        chk("t3_mip_clear", 32'(csr_mip_o[5]), 0);

        // NMI edge during external presentation
        ext = 1'b1; cyc();
        chk("t4_ext", 32'(irq_cause_o), 43);
        nm = 1'b1; cyc(); nm = 1'b0;
        chk("t4_no_preempt", 32'(irq_nmi_o), 0);
        ack_cyc(); cyc(); cyc();
        chk("t4_nmi", 32'(irq_nmi_o), 1);
        chk("t4_cause63", 32'(irq_cause_o), 63);
        ack_cyc(); cyc(); cyc();
        chk("t4_ext_back", 32'(irq_cause_o), 43);
        // Same with the core already in its NMI handler
        nmi_mode = 1'b1;
        nm = 1'b1; cyc(); nm = 1'b0;
        ack_cyc(); cyc(); cyc();
        chk("t4_nmi_blocked", 32'(irq_nmi_o), 0);
        ext = 1'b0; cyc(); cyc(); cyc();
        chk("t4_held_pending", 32'(irq_req_o), 0);
        nmi_mode = 1'b0; cyc();
        chk("t4_nmi_late", 32'(irq_nmi_o), 1);
        ack_cyc(); cyc(); cyc(); cyc();
        chk("t4_done", 32'(irq_req_o), 0);

        // Software withdrawn by clearing msie
        sw = 1'b1; cyc();
        chk("t5_cause35", 32'(irq_cause_o), 35);
        mie[1] = 1'b0; cyc();
        chk("t5_withdrawn", 32'(irq_req_o), 0);
        ack_cyc(); cyc();
        chk("t5_idle_ack", 32'(irq_req_o), 0);
        sw = 1'b0; mie = '1; cyc();

        // Debug mode blocks presentation of a pending level source
        dbg = 1'b1; tmr = 1'b1; cyc(); cyc();
        chk("t5_debug", 32'(irq_req_o), 0);
        dbg = 1'b0; cyc();
        chk("t5_debug_exit", 32'(irq_cause_o), 39);
        tmr = 1'b0; cyc(); cyc();

        // Reset while presenting NMI with an edge fast line pending
        nm = 1'b1; fast[2] = 1'b1; cyc();
        nm = 1'b0; fast[2] = 1'b0;
        chk("t6_nmi", 32'(irq_nmi_o), 1);
        cyc();
        chk("t6_mip", 32'(csr_mip_o[5]), 1);
        rst = 1'b1; cyc();
        chk("t6_rst_req", 32'(irq_req_o), 0);
        chk("t6_rst_nmi", 32'(irq_nmi_o), 0);
        chk("t6_rst_mip", 32'(csr_mip_o), 0);
        rst = 1'b0;
        cyc(); cyc(); cyc();
        chk("t6_lost_req", 32'(irq_req_o), 0);
        chk("t6_lost_mip", 32'(csr_mip_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
